// File: rtl/ex_stage_pipe_if.sv
// ex_stage_pipe_if: handshake bundle between ID/EX, the execute stage and MEM.
//   in_valid/in_ready        : ID offers an operation / stage can accept it
//   in_op, in_data1/2        : opcode and operands (rs1, rs2 or immediate)
//   in_we, in_waddr          : destination write enable / register
//   out_valid/out_ready      : result held for MEM / MEM consumes it
//   out_we/out_waddr/wdata   : registered write-back triple
// master = environment side (ID driver + MEM sink), slave = execute stage.
interface ex_stage_pipe_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned OP_W       = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [OP_W-1:0]       in_op;
  logic [XLEN-1:0]       in_data1;
  logic [XLEN-1:0]       in_data2;
  logic                  in_we;
  logic [REG_ADDR_W-1:0] in_waddr;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_we;
  logic [REG_ADDR_W-1:0] out_waddr;
  logic [XLEN-1:0]       out_wdata;

  modport master (
    output in_valid, in_op, in_data1, in_data2, in_we, in_waddr, out_ready,
    input  in_ready, out_valid, out_we, out_waddr, out_wdata
  );

  modport slave (
    input  in_valid, in_op, in_data1, in_data2, in_we, in_waddr, out_ready,
    output in_ready, out_valid, out_we, out_waddr, out_wdata
  );
endinterface

// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: handshaked RV32I/RV32M execute stage.
// Single-cycle ALU ops (and divide special cases) load the output register at
// acceptance; MUL*/DIV*/REM* iterate XLEN cycles (shift-add / restoring
// division over magnitudes) with sign correction on the final step.
// Ports:
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_flush  : synchronous abort of in-flight and held operation
//   o_busy   : multi-cycle iteration in progress
//   ex_if    : slave side of ex_stage_pipe_if (input handshake + write-back)
module ex_stage_pipe #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned OP_W       = 5
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_flush,
  output logic           o_busy,
  ex_stage_pipe_if.slave ex_if
);

  localparam int unsigned SHW  = $clog2(XLEN);
  localparam int unsigned CNTW = SHW + 1;

  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_MUL   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_MULH  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_MULHU = OP_W'(12);
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(13);
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(14);
  localparam logic [OP_W-1:0] OP_REM   = OP_W'(15);
  localparam logic [OP_W-1:0] OP_REMU  = OP_W'(16);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t                r_state;
  logic [CNTW-1:0]       r_cnt;
  logic [2*XLEN-1:0]     r_p;      // MUL: {acc_hi, multiplier}; DIV: {rem, quot}
  logic [XLEN-1:0]       r_a;      // multiplicand or divisor magnitude
  logic                  r_sel_hi; // take upper half (MULH*, REM*)
  logic                  r_neg;    // negate final result
  logic                  r_it_we;
  logic [REG_ADDR_W-1:0] r_it_waddr;

  logic                  r_out_valid;
  logic                  r_out_we;
  logic [REG_ADDR_W-1:0] r_out_waddr;
  logic [XLEN-1:0]       r_out_wdata;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_is_mul;
  logic                  w_is_div;
  logic                  w_signed;
  logic                  w_s1;
  logic                  w_s2;
  logic [XLEN-1:0]       w_mag1;
  logic [XLEN-1:0]       w_mag2;
  logic                  w_div_zero;
  logic                  w_div_ovf;
  logic                  w_go_mul;
  logic                  w_go_div;
  logic [SHW-1:0]        w_shamt;
  logic [XLEN-1:0]       w_alu;
  logic [XLEN:0]         w_mul_sum;
  logic [XLEN:0]         w_div_shift;
  logic [XLEN:0]         w_div_trial;
  logic [2*XLEN-1:0]     w_step;
  logic [2*XLEN-1:0]     w_prod;
  logic [XLEN-1:0]       w_half;
  logic [XLEN-1:0]       w_final;
  logic                  w_finish;

  // ---------------- handshake ----------------
  assign o_busy         = (r_state != S_IDLE);
  assign w_ready        = i_rst_n && !o_busy && (!r_out_valid || ex_if.out_ready);
  assign w_accept       = ex_if.in_valid && w_ready && !i_flush;
  assign ex_if.in_ready = w_ready;

  assign ex_if.out_valid = r_out_valid;
  assign ex_if.out_we    = r_out_we;
  assign ex_if.out_waddr = r_out_waddr;
  assign ex_if.out_wdata = r_out_wdata;

  // ---------------- operand preparation ----------------
  assign w_is_mul   = (ex_if.in_op == OP_MUL) || (ex_if.in_op == OP_MULH) ||
                      (ex_if.in_op == OP_MULHU);
  assign w_is_div   = (ex_if.in_op == OP_DIV) || (ex_if.in_op == OP_DIVU) ||
                      (ex_if.in_op == OP_REM) || (ex_if.in_op == OP_REMU);
  assign w_signed   = (ex_if.in_op == OP_MUL) || (ex_if.in_op == OP_MULH) ||
                      (ex_if.in_op == OP_DIV) || (ex_if.in_op == OP_REM);
  assign w_s1       = w_signed && ex_if.in_data1[XLEN-1];
  assign w_s2       = w_signed && ex_if.in_data2[XLEN-1];
  assign w_mag1     = w_s1 ? -ex_if.in_data1 : ex_if.in_data1;
  assign w_mag2     = w_s2 ? -ex_if.in_data2 : ex_if.in_data2;
  assign w_div_zero = (ex_if.in_data2 == '0);
  assign w_div_ovf  = ((ex_if.in_op == OP_DIV) || (ex_if.in_op == OP_REM)) &&
                      (ex_if.in_data1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (ex_if.in_data2 == '1);
  assign w_go_mul   = w_is_mul;
  assign w_go_div   = w_is_div && !w_div_zero && !w_div_ovf;
  assign w_shamt    = ex_if.in_data2[SHW-1:0];

  // ---------------- single-cycle result ----------------
  always_comb begin
    w_alu = '0;
    case (ex_if.in_op)
      OP_ADD:  w_alu = ex_if.in_data1 + ex_if.in_data2;
      OP_SUB:  w_alu = ex_if.in_data1 - ex_if.in_data2;
      OP_AND:  w_alu = ex_if.in_data1 & ex_if.in_data2;
      OP_OR:   w_alu = ex_if.in_data1 | ex_if.in_data2;
      OP_XOR:  w_alu = ex_if.in_data1 ^ ex_if.in_data2;
      OP_SLL:  w_alu = ex_if.in_data1 << w_shamt;
      OP_SRL:  w_alu = ex_if.in_data1 >> w_shamt;
      OP_SRA:  w_alu = $signed(ex_if.in_data1) >>> w_shamt;
      OP_SLT:  w_alu = {{(XLEN-1){1'b0}},
                        ($signed(ex_if.in_data1) < $signed(ex_if.in_data2))};
      OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, (ex_if.in_data1 < ex_if.in_data2)};
      // Divide special cases; normal divides go through the DIV state.
      OP_DIV:  w_alu = w_div_zero ? '1 : ex_if.in_data1;
      OP_DIVU: w_alu = '1;
      OP_REM:  w_alu = w_div_zero ? ex_if.in_data1 : '0;
      OP_REMU: w_alu = ex_if.in_data1;
      default: w_alu = '0;
    endcase
  end

  // ---------------- iteration step ----------------
  assign w_mul_sum   = {1'b0, r_p[2*XLEN-1:XLEN]} + (r_p[0] ? {1'b0, r_a} : '0);
  assign w_div_shift = {r_p[2*XLEN-1:XLEN], r_p[XLEN-1]};
  assign w_div_trial = w_div_shift - {1'b0, r_a};

  always_comb begin
    w_step = '0;
    if (r_state == S_MUL) begin
      w_step = {w_mul_sum, r_p[XLEN-1:1]};
    end else if (w_div_trial[XLEN]) begin
      w_step = {w_div_shift[XLEN-1:0], r_p[XLEN-2:0], 1'b0};
    end else begin
      w_step = {w_div_trial[XLEN-1:0], r_p[XLEN-2:0], 1'b1};
    end
  end

  // Product sign is fixed over the full 2*XLEN value before picking a half;
  // quotient/remainder are corrected independently after selection.
  always_comb begin
    w_prod  = '0;
    w_half  = '0;
    w_final = '0;
    if (r_state == S_MUL) begin
      w_prod  = r_neg ? -w_step : w_step;
      w_final = r_sel_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
    end else begin
      w_half  = r_sel_hi ? w_step[2*XLEN-1:XLEN] : w_step[XLEN-1:0];
      w_final = r_neg ? -w_half : w_half;
    end
  end

  assign w_finish = o_busy && (r_cnt == CNTW'(XLEN-1)) && !i_flush;

  // ---------------- FSM / iteration state ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_p        <= '0;
      r_a        <= '0;
      r_sel_hi   <= 1'b0;
      r_neg      <= 1'b0;
      r_it_we    <= 1'b0;
      r_it_waddr <= '0;
    end else if (i_flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && (w_go_mul || w_go_div)) begin
            r_cnt      <= '0;
            r_it_we    <= ex_if.in_we;
            r_it_waddr <= ex_if.in_waddr;
            if (w_go_mul) begin
              r_state  <= S_MUL;
              r_p      <= {{XLEN{1'b0}}, w_mag2};
              r_a      <= w_mag1;
              r_sel_hi <= (ex_if.in_op != OP_MUL);
              r_neg    <= w_s1 ^ w_s2;
            end else begin
              r_state  <= S_DIV;
              r_p      <= {{XLEN{1'b0}}, w_mag1};
              r_a      <= w_mag2;
              r_sel_hi <= (ex_if.in_op == OP_REM) || (ex_if.in_op == OP_REMU);
              r_neg    <= (ex_if.in_op == OP_REM) ? w_s1 : (w_s1 ^ w_s2);
            end
          end
        end
        default: begin
          r_p   <= w_step;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNTW'(XLEN-1)) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // ---------------- output register ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_out_we    <= 1'b0;
      r_out_waddr <= '0;
      r_out_wdata <= '0;
    end else if (i_flush) begin
      r_out_valid <= 1'b0;
      r_out_we    <= 1'b0;
    end else if (w_accept && !w_go_mul && !w_go_div) begin
      r_out_valid <= 1'b1;
      r_out_we    <= ex_if.in_we;
      r_out_waddr <= ex_if.in_waddr;
      r_out_wdata <= w_alu;
    end else if (w_finish) begin
      r_out_valid <= 1'b1;
      r_out_we    <= r_it_we;
      r_out_waddr <= r_it_waddr;
      r_out_wdata <= w_final;
    end else if (r_out_valid && ex_if.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/ex_stage_pipe.md
# ex_stage_pipe

Parametrised, handshaked execute stage for the RISC-V core, replacing the purely combinational EX path. It executes all RV32I register/immediate ALU operations in one cycle and the RV32M multiply/divide operations iteratively. It accepts decoded operands from ID/EX through a valid/ready handshake and presents a registered write-back triple (we, waddr, wdata) to the MEM side with back-pressure. It also supports a synchronous pipeline flush.

## Interface
- XLEN, default 32: datapath width; must be a power of two, at least 8.
- REG_ADDR_W, default 5: register-address width.
- OP_W, default 5: opcode width.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (low = reset asserted).
- flush  in  1  synchronous abort of the in-flight and held operation.
- in_valid  in  1  ID offers an operation.
- in_ready  out  1  stage can accept this cycle.
- in_op  in  OP_W  operation code (listed below).
- in_data1, in_data2  in  XLEN  operands (rs1, rs2/imm).
- in_we  in  1  destination-write enable.
- in_waddr  in  REG_ADDR_W  destination register.
- out_valid  out  1  result held for MEM.
- out_ready  in  1  MEM consumes the result.
- out_we  out  1  registered write enable.
- out_waddr  out  REG_ADDR_W  registered destination.
- out_wdata  out  XLEN  registered result.
- busy  out  1  multi-cycle iteration in progress.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL, 11 MULH, 12 MULHU, 13 DIV, 14 DIVU, 15 REM, 16 REMU.
- Opcodes 17 and above produce result 0; in_we is passed through unchanged.
- Shifts:
  - The shift amount is in_data2[$clog2(XLEN)-1:0].
  - SRA fills with data1[XLEN-1].
- SLT and SLTU write 1 when true, 0 when false. SLT is a two's-complement signed compare.
- Single-cycle ops (opcodes 0–9 and 17+) write the result directly into the output register.
- FSM states: IDLE, MUL, DIV.

**MUL state (opcodes 10–12)**
- Shift-add over operand magnitudes into a 2·XLEN product.
- Runs for exactly XLEN iterations.
- Sign correction is applied at the end:
  - MULH: signed × signed.
  - MULHU: unsigned × unsigned.
  - MUL: low XLEN bits.
  - MULH and MULHU: high XLEN bits.

**DIV state (opcodes 13–16)**
- Restoring division over magnitudes.
- Runs for exactly XLEN iterations.
- Sign rules:
  - The quotient is negative when the operand signs differ.
  - The remainder takes the sign of the dividend.

**Divide special cases (no DIV state entered; handled as single-cycle)**
- Divisor 0: quotient = all ones; remainder = dividend.
- Signed overflow (dividend = −2^(XLEN−1), divisor = −1): quotient = dividend; remainder = 0.

**Shared controls**
- Iteration counter width: $clog2(XLEN)+1.
- we and waddr are captured at acceptance and travel with the operation.

**Flush**
- Clears out_valid and out_we.
- Returns the FSM to IDLE and drops any partial result.
- Flush wins over in_valid in the same cycle: nothing is accepted.

**Reset (rst low)**
- Registered outputs go to 0 and the FSM goes to IDLE.
- All registered outputs are 0: out_valid, out_we, out_waddr, out_wdata, busy.
- in_ready is 0 while rst is low.

## Timing
- in_ready = rst && !busy && (!out_valid || out_ready). It is combinational.
- Accept = in_valid && in_ready at a rising edge.
- Single-cycle op accepted at edge N:
  - out_valid is 1 after edge N.
  - Back-to-back throughput is 1 per cycle while out_ready = 1.
- Multi-cycle op accepted at edge N:
  - busy = 1 from edge N through edge N+XLEN.
  - At edge N+XLEN, busy falls and the result loads, with out_valid = 1.
  - Latency is XLEN cycles, e.g. 32 for the default XLEN.
- Consumption: out_valid drops at the edge where out_valid && out_ready, unless a new op is accepted at that same edge.
- Stall: while out_valid && !out_ready, out_we, out_waddr and out_wdata hold stable and in_ready = 0.
- The output slot is guaranteed free when an iteration finishes, because acceptance requires the slot to be empty or draining.
- Async reset asserted mid-iteration aborts it. After deassertion, the first accept is possible on the next edge.

## Test plan
- Reset, then ADD 5+7 (we=1, waddr=3) with out_ready=1 -> one cycle later out_valid=1, wdata=12, waddr=3; in_ready stays 1.
- SLT with 0xFFFFFFFF, 1 -> 1; SLTU with the same operands -> 0; SRA 0x80000000 by 4 -> 0xF8000000; SRL by 36 -> uses shift amount 4.
- MULH 0x80000000 × 0x80000000 -> 0x40000000 after 32 cycles with busy=1 throughout; in_ready=0 while busy.
- DIV −7/2 -> 0xFFFFFFFD; REM −7/2 -> 0xFFFFFFFF; DIVU x/0 -> 0xFFFFFFFF after 1 cycle; DIV 0x80000000/−1 -> 0x80000000 with REM = 0.
- out_ready held low for 3 cycles after a result -> outputs stable and in_ready=0; out_ready raised -> next op is accepted that same cycle.
- flush at iteration 10 of a DIVU -> busy=0 and out_valid stays 0 on the next edge; rst pulsed low mid-MUL -> all outputs 0 immediately.
